// File: rtl/wm8978_vol_ctrl_if.sv
// I2C driver handshake bundle shared by the volume controller (master) and driver (slave).
interface wm8978_vol_ctrl_if;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        i2c_done;

  modport master (output i2c_exec, output i2c_data, input i2c_done);
  modport slave  (input i2c_exec, input i2c_data, output i2c_done);
endinterface

// File: rtl/wm8978_vol_ctrl.sv
// WM8978 runtime volume controller and I2C owner arbiter.
// Define VOL_PHONE_EN to also rewrite headphone volume (R52..R55); default writes R54/R55 only.
module wm8978_vol_ctrl #(
  parameter logic [5:0] INIT_VOL = 6'd45,
  parameter logic [5:0] VOL_STEP = 6'd4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_done,
  input  logic                     cfg_exec,
  input  logic [15:0]              cfg_data,
  input  logic                     vol_up,
  input  logic                     vol_down,
  wm8978_vol_ctrl_if.master        i2c,
  output logic                     busy,
  output logic [5:0]               volume
);

`ifdef VOL_PHONE_EN
  localparam int unsigned IDX_W    = 2;
  localparam logic [6:0]  BASE_REG = 7'd52;
`else
  localparam int unsigned IDX_W    = 1;
  localparam logic [6:0]  BASE_REG = 7'd54;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [5:0]       vol_q, vol_d;
  logic [15:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             exec_q, exec_d;
  logic             pend_q, pend_d;
  logic             pend_up_q, pend_up_d;

  logic             req_vld;
  logic             apply_up;
  logic [6:0]       vol_sum, vol_dif, wr_addr;
  logic [5:0]       vol_up_sat, vol_dn_sat;

  assign req_vld    = cfg_done & (vol_up ^ vol_down);
  // A fresh pulse in IDLE is newer than any pending one, so it wins.
  assign apply_up   = req_vld ? vol_up : pend_up_q;
  assign vol_sum    = {1'b0, vol_q} + {1'b0, VOL_STEP};
  assign vol_dif    = {1'b0, vol_q} - {1'b0, VOL_STEP};
  assign vol_up_sat = vol_sum[6] ? 6'd63 : vol_sum[5:0];
  assign vol_dn_sat = vol_dif[6] ? 6'd0  : vol_dif[5:0];
  assign wr_addr    = BASE_REG + 7'(idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vol_d     = vol_q;
    data_d    = data_q;
    busy_d    = busy_q;
    exec_d    = 1'b0;
    pend_d    = pend_q;
    pend_up_d = pend_up_q;

    if (busy_q && req_vld) begin
      pend_d    = 1'b1;
      pend_up_d = vol_up;
    end

    case (state_q)
      S_IDLE: begin
        if (req_vld || pend_q) begin
          vol_d   = apply_up ? vol_up_sat : vol_dn_sat;
          idx_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_d  = 1'b1;
        // Odd registers (R53/R55) carry the update bit plus the extra control bit.
        data_d  = {wr_addr, (wr_addr[0] ? 3'b110 : 3'b010), vol_q};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i2c.i2c_done) begin
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!cfg_done) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      exec_d  = 1'b0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      vol_q     <= INIT_VOL;
      data_q    <= '0;
      busy_q    <= 1'b0;
      exec_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vol_q     <= vol_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      exec_q    <= exec_d;
      pend_q    <= pend_d;
      pend_up_q <= pend_up_d;
    end
  end

  assign i2c.i2c_exec = cfg_done ? exec_q : cfg_exec;
  assign i2c.i2c_data = cfg_done ? data_q : cfg_data;
  assign busy         = busy_q;
  assign volume       = vol_q;

endmodule

// File: tb/tb_wm8978_vol_ctrl.sv
// Self-checking bench for wm8978_vol_ctrl: driver model answers each exec with a done 10 cycles later.
module tb_wm8978_vol_ctrl;
`ifdef VOL_PHONE_EN
  localparam int NWR   = 4;
  localparam int FIRST = 52;
`else
  localparam int NWR   = 2;
  localparam int FIRST = 54;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_done = 1'b0;
  logic        cfg_exec = 1'b0;
  logic [15:0] cfg_data = '0;
  logic        vol_up = 1'b0;
  logic        vol_down = 1'b0;
  logic        busy;
  logic [5:0]  volume;
  logic        drv_done = 1'b0;
  logic        stray_done = 1'b0;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          mdl_v  = 45;

  logic [15:0] words[$];
  int          cnt = 0;
  logic        prev_exec = 1'b0;
  logic [15:0] last_word = '0;
  logic        have_word = 1'b0;
  int          dbl_exec = 0;
  int          hold_err = 0;

  wm8978_vol_ctrl_if bus();
  assign bus.i2c_done = drv_done | stray_done;

  wm8978_vol_ctrl #(.INIT_VOL(6'd45), .VOL_STEP(6'd4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_done (cfg_done),
    .cfg_exec (cfg_exec),
    .cfg_data (cfg_data),
    .vol_up   (vol_up),
    .vol_down (vol_down),
    .i2c      (bus.master),
    .busy     (busy),
    .volume   (volume)
  );

  always #5 clk = ~clk;

  // Driver model: logs every word, replies 10 cycles later, watches pulse width and data hold.
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 0;
      drv_done  <= 1'b0;
      prev_exec <= 1'b0;
      have_word <= 1'b0;
    end else begin
      drv_done <= 1'b0;
      if (bus.i2c_exec) begin
        words.push_back(bus.i2c_data);
        cnt <= 10;
        if (prev_exec) dbl_exec <= dbl_exec + 1;
        if (cfg_done) begin
          last_word <= bus.i2c_data;
          have_word <= 1'b1;
        end
      end else begin
        if (cnt == 1) drv_done <= 1'b1;
        if (cnt > 0) cnt <= cnt - 1;
        if (cfg_done && have_word && busy && bus.i2c_data !== last_word) hold_err <= hold_err + 1;
      end
      prev_exec <= bus.i2c_exec;
    end
  end

  function automatic int sat_step(input int v, input bit up);
    int r;
    r = up ? v + 4 : v - 4;
    if (r > 63) r = 63;
    if (r < 0) r = 0;
    return r;
  endfunction

  function automatic logic [15:0] exp_word(input int i, input int v);
    int r;
    r = FIRST + i;
    return 16'((r * 512) + (((r % 2) == 1) ? 6 : 2) * 64 + v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input bit u, input bit d);
    vol_up = u;
    vol_down = d;
    tick();
    vol_up = 1'b0;
    vol_down = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000 && busy; k++) tick();
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 200 && words.size() < n; k++) tick();
    check("exec_seen", words.size() >= n, 1'b1);
  endtask

  task automatic check_words(input int base, input int v);
    check("write_count", words.size() - base, NWR);
    for (int i = 0; i < NWR; i++)
      if (base + i < words.size()) check("write_word", words[base + i], exp_word(i, v));
  endtask

  task automatic run_key(input bit up);
    int base;
    base = words.size();
    mdl_v = sat_step(mdl_v, up);
    key(up, !up);
    check("vol_update", volume, mdl_v);
    check("busy_rise", busy, 1'b1);
    tick();
    check("exec_latency", bus.i2c_exec, 1'b1);
    check("first_word", bus.i2c_data, exp_word(0, mdl_v));
    wait_idle();
    check_words(base, mdl_v);
    check("vol_hold", volume, mdl_v);
  endtask

  initial begin
    int base;
    int v1;
    int v2;

    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_volume", volume, 45);
    check("rst_exec", bus.i2c_exec, 1'b0);
    rst_n = 1'b1;
    tick();

    // Pass-through while configuration runs
    cfg_data = 16'h0201;
    cfg_exec = 1'b1;
    #1;
    check("pt_exec", bus.i2c_exec, 1'b1);
    check("pt_data", bus.i2c_data, 16'h0201);
    tick();
    cfg_exec = 1'b0;
    key(1'b1, 1'b0);
    check("pt_key_dropped", volume, 45);
    check("pt_not_busy", busy, 1'b0);
    repeat (20) tick();

    // Ownership taken: cfg inputs ignored, internal word still at reset value
    cfg_done = 1'b1;
    cfg_exec = 1'b1;
    cfg_data = 16'hFFFF;
    #1;
    check("own_exec", bus.i2c_exec, 1'b0);
    check("own_data", bus.i2c_data, 16'h0000);
    tick();
    cfg_exec = 1'b0;

    // Single up, then saturation at the top (extra up at 63 still writes)
    run_key(1'b1);
    check("single_up_49", volume, 49);
    repeat (5) run_key(1'b1);
    check("sat_top", volume, 63);

    // Randomised key mix
    for (int n = 0; n < 10; n++) run_key(1'($urandom_range(0, 1)));

    // Down to zero plus one more down at the floor
    for (int n = 0; n < 20 && mdl_v > 0; n++) run_key(1'b0);
    run_key(1'b0);
    check("sat_floor", volume, 0);

    // Pending: down in first WAIT, up in second WAIT, last wins
    base = words.size();
    v1 = sat_step(mdl_v, 1'b1);
    key(1'b1, 1'b0);
    wait_words(base + 1);
    repeat (2) tick();
    key(1'b0, 1'b1);
    wait_words(base + 2);
    repeat (2) tick();
    key(1'b1, 1'b0);
    check("pend_not_midseq", volume, v1);
    wait_idle();
    check_words(base, v1);
    check("pend_idle_vol", volume, v1);
    v2 = sat_step(v1, 1'b1);
    tick();
    check("pend_busy", busy, 1'b1);
    check("pend_vol", volume, v2);
    base = words.size();
    tick();
    check("pend_exec", bus.i2c_exec, 1'b1);
    check("pend_word0", bus.i2c_data, exp_word(0, v2));
    wait_idle();
    check_words(base, v2);
    mdl_v = v2;
    repeat (30) tick();
    check("pend_single_followup", words.size() - base, NWR);

    // Simultaneous up+down ignored
    base = words.size();
    key(1'b1, 1'b1);
    repeat (20) tick();
    check("simul_no_exec", words.size() - base, 0);
    check("simul_vol", volume, mdl_v);
    check("simul_busy", busy, 1'b0);

    // Reset in WAIT after the second write
    base = words.size();
    key(1'b1, 1'b0);
    wait_words(base + 2);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_exec", bus.i2c_exec, 1'b0);
    check("mid_rst_vol", volume, 45);
    mdl_v = 45;
    tick();
    rst_n = 1'b1;
    tick();
    base = words.size();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (20) tick();
    check("stray_done_ignored", words.size() - base, 0);
    check("stray_busy", busy, 1'b0);

    check("exec_single_cycle", dbl_exec, 0);
    check("data_hold", hold_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wm8978_vol_ctrl.md
# wm8978_vol_ctrl

Runtime volume controller and I2C owner arbiter for the WM8978 codec path. During power-up it passes the register-configuration sequencer's I2C requests straight through to the I2C driver. Once configuration completes, it permanently takes ownership of the driver. It then turns volume up/down key pulses into saturated volume updates and re-issues the output-volume register writes (R52–R55) through the driver's exec/done handshake.

## Interface
Parameters:
- `INIT_VOL`, 6'd45: volume value after reset; it matches the level written by the configuration sequence.
- `VOL_STEP`, 6'd4: increment or decrement applied per accepted key pulse.

Ports:
- `clk`, input, 1: driver clock, typically 1 MHz, shared with the I2C driver.
- `rst_n`, input, 1: asynchronous active-low reset.
- `cfg_done`, input, 1: configuration sequencer finished; level, sticky.
- `cfg_exec`, input, 1: configuration sequencer's I2C trigger pulse.
- `cfg_data`, input, 16: configuration sequencer's word, {7-bit reg addr, 9-bit data}.
- `vol_up`, input, 1: single-cycle pulse (debounced key) requesting a volume increase.
- `vol_down`, input, 1: single-cycle pulse requesting a volume decrease.
- `i2c_done`, input, 1: single-cycle completion pulse from the I2C driver.
- `i2c_exec`, output, 1: trigger to the I2C driver.
- `i2c_data`, output, 16: word to the I2C driver.
- `busy`, output, 1: high while a volume write sequence is in progress.
- `volume`, output, 6: current volume, 0–63.

## Operation
- **Ownership**
  - While `cfg_done`=0: `i2c_exec`=`cfg_exec` and `i2c_data`=`cfg_data`, combinational pass-through. The internal FSM is held in IDLE.
  - `vol_up`/`vol_down` are dropped while `cfg_done`=0.
  - While `cfg_done`=1: `i2c_exec` and `i2c_data` come from internal registers; `cfg_exec` and `cfg_data` are ignored.
- **Volume arithmetic**
  - Computed in 7 bits, then saturated.
  - Up: `volume` = min(`volume`+`VOL_STEP`, 63).
  - Down: `volume` = max(`volume`−`VOL_STEP`, 0). A would-be negative result clamps to 0.
  - `vol_up` and `vol_down` both high in the same cycle: the request is ignored entirely.
- **FSM states**
  - IDLE
    - On a request (or a pending request): update `volume`, set write index to the first write, set `busy`=1, go to EXEC.
    - A request that leaves `volume` unchanged at a saturation limit still runs the write sequence.
  - EXEC
    - Load `i2c_data` = word(index) and pulse `i2c_exec` for exactly one cycle.
    - Go to WAIT.
  - WAIT
    - On `i2c_done`, if the index is the last write: go to IDLE and clear `busy`. The pending check happens in IDLE on the next cycle.
    - On `i2c_done` otherwise: increment the index and go to EXEC.
    - Without `i2c_done`: stay in WAIT indefinitely. There is no timeout.
- **Write words** (v = `volume`):
  - R52 {7'd52, 3'b010, v}
  - R53 {7'd53, 3'b110, v}
  - R54 {7'd54, 3'b010, v}
  - R55 {7'd55, 3'b110, v}
- **Pending request**
  - A valid up/down pulse arriving while `busy`=1 is stored in a one-deep pending register. A later pulse overwrites it (last wins).
  - The pending request is applied on the IDLE cycle after the sequence ends.
  - It is never applied to `volume` mid-sequence, so all writes in one sequence carry the same v.

## Timing
- **Reset values:** `i2c_exec`=0, internal `i2c_data`=16'h0000, `busy`=0, `volume`=`INIT_VOL`, pending cleared, FSM=IDLE, index=first write.
- **Request latency**
  - Pulse sampled at edge N: `volume` and `busy` update after edge N.
  - `i2c_exec`=1 with valid `i2c_data` after edge N+1, for one cycle.
- **Between writes:** `i2c_done` sampled at edge M gives the next `i2c_exec` after edge M+1.
- **Data hold:** `i2c_data` stays stable from its `i2c_exec` until the next EXEC load.
- **Pending restart:** the last `i2c_done` at edge M gives IDLE after M. The new `volume` updates after M+1, and `i2c_exec` follows after M+2.
- **`i2c_done` outside WAIT:** ignored.
- **Reset mid-sequence:** all state returns to reset values immediately. No further `i2c_exec` is issued until a new request arrives with `cfg_done`=1.

## Configuration
- **`VOL_PHONE_EN` defined:** the sequence is R52, R53, R54, R55 (4 writes); headphone and speaker track the same volume.
- **`VOL_PHONE_EN` undefined:** the sequence is R54, R55 only (2 writes); headphone volume stays at its configured value. Index width and last-write detection adjust accordingly.

## Test plan
- **Pass-through:** `cfg_done`=0, `cfg_exec` pulse with `cfg_data`=16'h0201 → `i2c_exec` pulse the same cycle with `i2c_data`=16'h0201. A `vol_up` in this window leaves `volume`=45.
- **Single up:** `cfg_done`=1, `vol_up`, driver model returns `i2c_done` 10 cycles after each exec → `volume`=49.
  - `VOL_PHONE_EN` defined: 4 exec pulses with words 16'h68B1, 16'h6BB1, 16'h6CB1, 16'h6FB1.
  - Undefined: 2 pulses, 16'h6CB1 then 16'h6FB1.
  - `busy` falls after the last done.
- **Saturation:** 5 × `vol_up` spaced by full sequences from 45 → 49, 53, 57, 61, 63. `vol_down` repeated from 5 → 1, then 0, with a sequence still issued at 0.
- **Pending and simultaneous:** `vol_down` during the first WAIT, then `vol_up` during the second WAIT → one follow-up sequence at `volume` = original+4. `vol_up` and `vol_down` high together in IDLE → no exec and `volume` unchanged.
- **Reset mid-sequence:** assert `rst_n`=0 in WAIT after the second write → `busy`=0, `i2c_exec`=0, `volume`=45 immediately. After release, a stray `i2c_done` produces no exec.
